// File: rtl/core_pkg.sv
// Shared core definitions: default datapath widths and the control bundle that
// travels with an instruction through the ID/EX, EX/MEM and MEM/WB stages.
package core_pkg;

    localparam int CORE_DATA_W = 16;
    localparam int CORE_REG_AW = 3;

    typedef struct packed {
        logic reg_we;
        logic mem_re;
        logic mem_we;
        logic halt;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/dff_en_clr.sv
// Generic pipeline register with synchronous reset and clear (clear beats
// enable) and a load enable.
module dff_en_clr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: non-blocking assignment so every flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fwd_compare.sv
// Bypass/load-use comparison for one EX source register against the
// instruction held in MEM.
module fwd_compare import core_pkg::*; #(
    parameter int REG_AW = CORE_REG_AW
) (
    input  logic              mem_valid,
    input  logic              mem_reg_we,
    input  logic              mem_mem_re,
    input  logic [REG_AW-1:0] mem_wr_reg,
    input  logic [REG_AW-1:0] ex_src,
    input  logic              ex_src_used,
    output logic              fwd,
    output logic              load_use
);

    logic hit;

    // Register 0 is an ordinary register here, so no zero-address exclusion.
    assign hit      = mem_valid & mem_reg_we & (mem_wr_reg == ex_src) & ex_src_used;
    assign fwd      = hit & ~mem_mem_re;
    assign load_use = hit & mem_mem_re;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register plus the EX-to-EX bypass selects and load-use
// hazard detection for the instruction currently in EX.
module ex_mem_stage import core_pkg::*; #(
    parameter int DATA_W = CORE_DATA_W,
    parameter int REG_AW = CORE_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic              ex_zf,
    input  logic              ex_of,
    input  logic              ex_sf,
    input  logic [DATA_W-1:0] ex_st_data,
    input  logic [REG_AW-1:0] ex_wr_reg,
    input  logic              ex_reg_we,
    input  logic              ex_mem_re,
    input  logic              ex_mem_we,
    input  logic              ex_halt,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_rs_used,
    input  logic              ex_rt_used,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_alu_out,
    output logic              mem_zf,
    output logic              mem_of,
    output logic              mem_sf,
    output logic [DATA_W-1:0] mem_st_data,
    output logic [REG_AW-1:0] mem_wr_reg,
    output logic              mem_reg_we,
    output logic              mem_mem_re,
    output logic              mem_mem_we,
    output logic              mem_halt,
    output logic              fwd_a,
    output logic              fwd_b,
    output logic [DATA_W-1:0] fwd_data,
    output logic              load_use
);

    localparam int STAGE_W = 1 + DATA_W + 3 + DATA_W + REG_AW + CTRL_W;

    ctrl_t               ctrl_d;
    ctrl_t               ctrl_q;
    logic [STAGE_W-1:0]  stage_d;
    logic [STAGE_W-1:0]  stage_q;
    logic                load_use_rs;
    logic                load_use_rt;

    // NOTE: default every always_comb output first so no path can infer a latch.
    always_comb begin
        ctrl_d = '0;
        if (ex_valid) begin
            ctrl_d.reg_we = ex_reg_we;
            ctrl_d.mem_re = ex_mem_re;
            ctrl_d.mem_we = ex_mem_we;
            ctrl_d.halt   = ex_halt;
        end
        stage_d = {ex_valid, ex_alu_out, ex_zf, ex_of, ex_sf, ex_st_data, ex_wr_reg, ctrl_d};
    end

    // Flush clears the whole stage (data included), which also keeps control
    // at zero whenever valid is zero.
    dff_en_clr #(.WIDTH(STAGE_W)) u_stage (
        .clk (clk),
        .rst (rst),
        .en  (~stall),
        .clr (flush),
        .d   (stage_d),
        .q   (stage_q)
    );

    assign {mem_valid, mem_alu_out, mem_zf, mem_of, mem_sf, mem_st_data, mem_wr_reg, ctrl_q} = stage_q;

    assign mem_reg_we = ctrl_q.reg_we;
    assign mem_mem_re = ctrl_q.mem_re;
    assign mem_mem_we = ctrl_q.mem_we;
    assign mem_halt   = ctrl_q.halt;
    assign fwd_data   = mem_alu_out;

    fwd_compare #(.REG_AW(REG_AW)) u_fwd_rs (
        .mem_valid   (mem_valid),
        .mem_reg_we  (mem_reg_we),
        .mem_mem_re  (mem_mem_re),
        .mem_wr_reg  (mem_wr_reg),
        .ex_src      (ex_rs),
        .ex_src_used (ex_rs_used),
        .fwd         (fwd_a),
        .load_use    (load_use_rs)
    );

    fwd_compare #(.REG_AW(REG_AW)) u_fwd_rt (
        .mem_valid   (mem_valid),
        .mem_reg_we  (mem_reg_we),
        .mem_mem_re  (mem_mem_re),
        .mem_wr_reg  (mem_wr_reg),
        .ex_src      (ex_rt),
        .ex_src_used (ex_rt_used),
        .fwd         (fwd_b),
        .load_use    (load_use_rt)
    );

    assign load_use = load_use_rs | load_use_rt;

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline stage directly downstream of the ALU in the 16-bit five-stage core.
- Registers the ALU result, the flags (ZF/OF/SF), store data and control for the memory stage.
- Produces the EX-to-EX bypass selects and bypass data that feed back to the ALU operand muxes.
- Detects a load-use hazard against the instruction currently in EX.

Parameters:
- DATA_W, 16, datapath width; matches the ALU operand width.
- REG_AW, 3, register-file address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold all stage registers.
- flush  in  1  load a bubble instead of the EX instruction.
- ex_valid  in  1  EX holds a real instruction.
- ex_alu_out  in  DATA_W  ALU Out.
- ex_zf, ex_of, ex_sf  in  1 each  ALU flags.
- ex_st_data  in  DATA_W  store data, post-bypass.
- ex_wr_reg  in  REG_AW  destination register.
- ex_reg_we, ex_mem_re, ex_mem_we, ex_halt  in  1 each  control bits.
- ex_rs, ex_rt  in  REG_AW  source registers of the instruction now in EX.
- ex_rs_used, ex_rt_used  in  1 each  the source is actually read.
- mem_valid  out  1  registered valid.
- mem_alu_out  out  DATA_W  registered result; used as memory address or writeback data.
- mem_zf, mem_of, mem_sf  out  1 each  registered flags.
- mem_st_data  out  DATA_W  registered store data.
- mem_wr_reg  out  REG_AW  registered destination register.
- mem_reg_we, mem_mem_re, mem_mem_we, mem_halt  out  1 each  registered control, qualified by valid.
- fwd_a, fwd_b  out  1 each  select the bypass for ALU operand A / B.
- fwd_data  out  DATA_W  bypass value, equal to mem_alu_out.
- load_use  out  1  EX consumer depends on a load now in MEM.

Behaviour:
- Update priority each rising edge: rst > flush > stall > load.
- rst: every registered output is 0, including mem_valid, data, flags, control and mem_wr_reg. Combinational outputs follow from the zeroed state, so fwd_a = fwd_b = load_use = 0.
- flush (rst=0):
  - mem_valid, mem_reg_we, mem_mem_re, mem_mem_we and mem_halt go to 0.
  - Data and flag registers are don't-care; the implementation clears them to 0.
  - flush overrides a simultaneous stall.
- stall (rst=0, flush=0): every register holds its value. Outputs remain stable for as many cycles as stall is asserted.
- load (rst=0, flush=0, stall=0):
  - All fields capture their ex_* inputs; latency is 1 cycle.
  - Control bits are stored as ex_ctrl AND ex_valid, so an invalid EX slot can never write the register file or memory.
- Invariant: whenever mem_valid=0, all mem control outputs are 0.
- A simultaneous ex_mem_re and ex_mem_we is illegal upstream. Both are registered as given; the bench checks the illegal case is never driven.
- Bypass:
  - hit_x = mem_valid & mem_reg_we & (mem_wr_reg == ex_x) & ex_x_used, for x in {rs, rt}.
  - fwd_a = hit_rs & ~mem_mem_re.
  - fwd_b = hit_rt & ~mem_mem_re.
  - fwd_data = mem_alu_out.
- Load-use: load_use = (hit_rs | hit_rt) & mem_mem_re. The hazard unit uses it to stall IF/ID/EX and flush this stage for one cycle.
- Bypass and load-use logic is purely combinational from the current state plus ex_rs/ex_rt; it has no extra latency.
- Register 0 is not special in this ISA: a match on address 0 forwards normally.
- mem_halt propagates like any other control bit; it is not sticky in this stage.

Decomposition:
- Shared package (core_pkg) holds DATA_W and REG_AW defaults and a ctrl bundle (reg_we, mem_re, mem_we, halt) with its width constant. The same bundle is reused by the ID/EX and MEM/WB stages.
- One natural sub-module: fwd_compare. It computes hit, fwd and load_use for one source register and is instantiated twice (rs, rt).
- Registers use a shared generic enable/clear flop, dff_en_clr, parameterised by width.

Test Plan:
- Reset: rst=1 with ex_valid=1 and ex_alu_out=16'h1234 -> after the edge all outputs are 0, mem_valid=0 and fwd_a=0.
- Load: ex_alu_out=16'hBEEF, ex_zf=0, ex_sf=1, ex_wr_reg=3, ex_reg_we=1, ex_valid=1 -> next cycle mem_alu_out=16'hBEEF, mem_sf=1, mem_wr_reg=3 and mem_reg_we=1.
- Stall: hold stall=1 for 3 cycles while the ex_* inputs change -> mem_* outputs remain at their prior values; on release the new inputs load in one cycle.
- Flush with stall: stall=1 and flush=1 with ex_mem_we=1 -> mem_valid=0 and mem_mem_we=0; flush wins.
- Bypass: MEM holds ADD r3 (reg_we=1, mem_re=0, alu_out=16'h0042); EX has ex_rs=3, ex_rs_used=1, ex_rt=3, ex_rt_used=0 -> fwd_a=1, fwd_b=0, fwd_data=16'h0042, load_use=0.
- Load-use and invalid slot:
  - MEM holds LD r5 (mem_re=1); EX has ex_rt=5 and ex_rt_used=1 -> load_use=1, fwd_b=0.
  - Repeat with ex_valid=0 at capture -> mem_reg_we=0 and load_use=0.
